// File: rtl/bp_common_pkg.sv
// Shared types for the cosim commit arbiter: the controller state enum and a
// width helper that keeps one-requester builds from producing zero-width ids.
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_cosim_idle,
    e_cosim_run,
    e_cosim_drain,
    e_cosim_done
  } bp_cosim_arb_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin grant selector: the search starts at the priority pointer, and
// after every grant the pointer moves to the granted requester plus one.
module bsg_arb_round_robin
  import bp_common_pkg::*;
#(
  parameter  int width_p      = 4,
  localparam int tag_width_lp = safe_clog2(width_p)
)(
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      reqs_i,
  input  logic                    grants_en_i,
  output logic [width_p-1:0]      grants_o,
  output logic                    v_o,
  output logic [tag_width_lp-1:0] tag_o
);

  logic [tag_width_lp-1:0] ptr_r;
  int unsigned             idx;

  always_comb begin
    v_o   = 1'b0;
    tag_o = '0;
    idx   = 0;
    for (int k = 0; k < width_p; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= width_p) idx = idx - width_p;
      if (!v_o && reqs_i[idx]) begin
        v_o   = 1'b1;
        tag_o = tag_width_lp'(idx);
      end
    end
  end

  always_comb begin
    grants_o = '0;
    for (int k = 0; k < width_p; k++)
      grants_o[k] = grants_en_i & v_o & (tag_o == tag_width_lp'(k));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      ptr_r <= '0;
    else if (grants_en_i && v_o)
      ptr_r <= (tag_o == tag_width_lp'(width_p - 1)) ? '0 : tag_o + 1'b1;
  end

endmodule

// File: rtl/bp_nonsynth_cosim_arb.sv
// Merges per-core commit records into one stream for the cosim checker and
// tracks pass/fail. Optional stall watchdog: define BP_COSIM_ARB_WATCHDOG_EN.
module bp_nonsynth_cosim_arb
  import bp_common_pkg::*;
#(
  parameter  int num_core_p     = 4,
  parameter  int commit_width_p = 128,
  parameter  int timeout_p      = 1024,
  localparam int id_width_lp    = safe_clog2(num_core_p)
)(
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     en_i,
  input  logic [31:0]                              instr_cap_i,
  input  logic [num_core_p-1:0]                    commit_v_i,
  input  logic [num_core_p-1:0][commit_width_p-1:0] commit_data_i,
  output logic [num_core_p-1:0]                    commit_ready_and_o,
  output logic                                     commit_v_o,
  output logic [commit_width_p-1:0]                commit_data_o,
  output logic [id_width_lp-1:0]                   commit_id_o,
  input  logic                                     commit_yumi_i,
  input  logic                                     mismatch_i,
  output logic                                     done_o,
  output logic                                     pass_o,
  output logic                                     fail_o,
  output logic [31:0]                              instr_cnt_o
);

  bp_cosim_arb_state_e state_r, state_n;

  logic [num_core_p-1:0]                     buf_v_r;
  logic [num_core_p-1:0][commit_width_p-1:0] buf_data_r;
  logic                                      out_v_r;
  logic [commit_width_p-1:0]                 out_data_r;
  logic [id_width_lp-1:0]                    out_id_r;
  logic [31:0]                               cnt_r, cnt_n;
  logic                                      pass_r, fail_r;

  logic                      active, yumi_fire, cap_hit, fail_fire, wd_fire;
  logic                      grant_en, enter_done, arb_v;
  logic [num_core_p-1:0]     reqs, grants, take, bypass;
  logic [id_width_lp-1:0]    arb_tag;
  logic [commit_width_p-1:0] sel_data;

  assign active    = (state_r == e_cosim_run) | (state_r == e_cosim_drain);
  assign yumi_fire = commit_yumi_i & out_v_r;
  assign cnt_n     = (yumi_fire && (cnt_r != '1)) ? cnt_r + 32'd1 : cnt_r;
  assign cap_hit   = (instr_cap_i != '0) && (cnt_n == instr_cap_i);
  assign fail_fire = active & (mismatch_i | wd_fire);

  // The cycle that hits the cap or fails must not load a record nobody will consume.
  assign grant_en = (state_r == e_cosim_run) & (~out_v_r | yumi_fire) & ~cap_hit & ~fail_fire;

  // An empty buffer lets its incoming record compete directly, saving a cycle.
  assign reqs = buf_v_r | commit_v_i;

  bsg_arb_round_robin #(.width_p(num_core_p)) arb (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .reqs_i     (reqs),
    .grants_en_i(grant_en),
    .grants_o   (grants),
    .v_o        (arb_v),
    .tag_o      (arb_tag)
  );

  assign commit_ready_and_o = {num_core_p{active}} & (~buf_v_r | grants);
  assign take               = commit_v_i & commit_ready_and_o;
  assign bypass             = grants & ~buf_v_r;
  assign sel_data           = buf_v_r[arb_tag] ? buf_data_r[arb_tag] : commit_data_i[arb_tag];

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_cosim_idle:  if (en_i) state_n = e_cosim_run;
      e_cosim_run:   if (fail_fire) state_n = e_cosim_done;
                     else if (cap_hit) state_n = e_cosim_drain;
      e_cosim_drain: if (fail_fire || !out_v_r) state_n = e_cosim_done;
      e_cosim_done:  state_n = e_cosim_done;
      default:       state_n = e_cosim_idle;
    endcase
  end

  assign enter_done = (state_r != e_cosim_done) && (state_n == e_cosim_done);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_cosim_idle;
      buf_v_r <= '0;
      cnt_r   <= '0;
      pass_r  <= 1'b0;
      fail_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      buf_v_r <= (take & ~bypass) | (buf_v_r & ~grants);
      cnt_r   <= cnt_n;
      if (enter_done) begin
        fail_r <= fail_fire;
        pass_r <= ~fail_fire;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_core_p; i++)
      if (take[i] && !bypass[i]) buf_data_r[i] <= commit_data_i[i];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v_r    <= 1'b0;
      out_data_r <= '0;
      out_id_r   <= '0;
    end else if (enter_done) begin
      out_v_r <= 1'b0;
    end else if (grant_en && arb_v) begin
      out_v_r    <= 1'b1;
      out_data_r <= sel_data;
      out_id_r   <= arb_tag;
    end else if (yumi_fire) begin
      out_v_r <= 1'b0;
    end
  end

`ifdef BP_COSIM_ARB_WATCHDOG_EN
  localparam int wd_width_lp = $clog2(timeout_p + 1);
  logic [wd_width_lp-1:0] wd_cnt_r;
  logic                   stall;

  assign stall   = active & out_v_r & ~commit_yumi_i;
  assign wd_fire = stall & (wd_cnt_r == wd_width_lp'(timeout_p - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  wd_cnt_r <= '0;
    else if (!stall) wd_cnt_r <= '0;
    else             wd_cnt_r <= wd_cnt_r + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign commit_v_o    = out_v_r;
  assign commit_data_o = out_data_r;
  assign commit_id_o   = out_id_r;
  assign done_o        = (state_r == e_cosim_done);
  assign pass_o        = pass_r;
  assign fail_o        = fail_r;
  assign instr_cnt_o   = cnt_r;

endmodule

// File: tb/tb_bp_nonsynth_cosim_arb.sv
// Directed bench for bp_nonsynth_cosim_arb with a queue-based scoreboard on the
// output handshake. Watchdog case runs only with BP_COSIM_ARB_WATCHDOG_EN.
module tb_bp_nonsynth_cosim_arb;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 16;

  logic                clk_i = 1'b0;
  logic                reset_n_i;
  logic                en_i;
  logic [31:0]         instr_cap_i;
  logic [N-1:0]        commit_v_i;
  logic [N-1:0][W-1:0] commit_data_i;
  logic [N-1:0]        commit_ready_and_o;
  logic                commit_v_o;
  logic [W-1:0]        commit_data_o;
  logic [1:0]          commit_id_o;
  logic                commit_yumi_i;
  logic                mismatch_i;
  logic                done_o, pass_o, fail_o;
  logic [31:0]         instr_cnt_o;

  bp_nonsynth_cosim_arb #(
    .num_core_p    (N),
    .commit_width_p(W),
    .timeout_p     (TO)
  ) dut (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
    .en_i              (en_i),
    .instr_cap_i       (instr_cap_i),
    .commit_v_i        (commit_v_i),
    .commit_data_i     (commit_data_i),
    .commit_ready_and_o(commit_ready_and_o),
    .commit_v_o        (commit_v_o),
    .commit_data_o     (commit_data_o),
    .commit_id_o       (commit_id_o),
    .commit_yumi_i     (commit_yumi_i),
    .mismatch_i        (mismatch_i),
    .done_o            (done_o),
    .pass_o            (pass_o),
    .fail_o            (fail_o),
    .instr_cnt_o       (instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [N-1:0] stream_mask;
  logic         yumi_en;
  int           hs_limit;
  int           mm_at_hs;
  int           hs_cnt;
  int           seq[N];
  int           acc_cnt[N];
  int           base[N];

  // Record k from core c carries {c, k} so every grant is identifiable.
  function automatic logic [W-1:0] rec(input int c, input int k);
    return W'((c << 12) | k);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic push_exp(input int id, input int k);
    exp_t e;
    e.id   = 2'(id);
    e.data = rec(id, k);
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every consumed record is compared with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #3;
      if (reset_n_i && commit_v_o && commit_yumi_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL mon_unexpected: got id %0d data 0x%0h, expected no record", commit_id_o, commit_data_o);
        end else begin
          e = exp_q.pop_front();
          check_output("mon_id", 32'(commit_id_o), 32'(e.id));
          check_output("mon_data", 32'(commit_data_o), 32'(e.data));
        end
      end
    end
  end

  // One clock of stimulus: streams per-core records, consumes when enabled.
  task automatic apply_stimulus();
    logic [N-1:0] acc;
    logic         hs;
    @(negedge clk_i);
    commit_v_i = stream_mask;
    for (int i = 0; i < N; i++) commit_data_i[i] = rec(i, seq[i]);
    #1;
    commit_yumi_i = yumi_en && commit_v_o && (hs_cnt < hs_limit);
    mismatch_i    = commit_yumi_i && (hs_cnt == mm_at_hs);
    #1;
    acc = commit_v_i & commit_ready_and_o;
    hs  = commit_v_o & commit_yumi_i;
    @(posedge clk_i);
    for (int i = 0; i < N; i++) if (acc[i]) begin seq[i]++; acc_cnt[i]++; end
    if (hs) hs_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_n_i     = 1'b0;
    en_i          = 1'b0;
    instr_cap_i   = '0;
    commit_v_i    = '0;
    commit_yumi_i = 1'b0;
    mismatch_i    = 1'b0;
    stream_mask   = '0;
    yumi_en       = 1'b0;
    hs_limit      = 1000;
    mm_at_hs      = -1;
    hs_cnt        = 0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; acc_cnt[i] = 0; end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic start_run();
    en_i        = 1'b1;
    stream_mask = '0;
    apply_stimulus();
  endtask

  initial begin
    reset_n_i     = 1'b0;
    en_i          = 1'b0;
    instr_cap_i   = '0;
    commit_v_i    = '0;
    commit_data_i = '0;
    commit_yumi_i = 1'b0;
    mismatch_i    = 1'b0;

    // Reset state, and IDLE refuses records while en_i is low.
    do_reset();
    #1;
    check_output("rst_commit_v", 32'(commit_v_o), 32'd0);
    check_output("rst_done", 32'(done_o), 32'd0);
    check_output("rst_pass", 32'(pass_o), 32'd0);
    check_output("rst_fail", 32'(fail_o), 32'd0);
    check_output("rst_instr_cnt", instr_cnt_o, 32'd0);
    check_output("rst_ready", 32'(commit_ready_and_o), 32'd0);
    stream_mask = 4'b1111;
    apply_stimulus();
    #1;
    check_output("idle_no_accept", 32'(acc_cnt[0] + acc_cnt[1] + acc_cnt[2] + acc_cnt[3]), 32'd0);
    check_output("idle_commit_v", 32'(commit_v_o), 32'd0);

    // Single record from core 2 appears on the next cycle.
    do_reset();
    start_run();
    exp_q.push_back(exp_t'{2'd2, 16'h00A5});
    @(negedge clk_i);
    commit_v_i       = 4'b0100;
    commit_data_i[2] = 16'h00A5;
    @(posedge clk_i);
    @(negedge clk_i);
    commit_v_i = '0;
    #1;
    check_output("single_v", 32'(commit_v_o), 32'd1);
    check_output("single_id", 32'(commit_id_o), 32'd2);
    check_output("single_data", 32'(commit_data_o), 32'h00A5);
    commit_yumi_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    commit_yumi_i = 1'b0;
    #1;
    check_output("single_cnt", instr_cnt_o, 32'd1);
    check_output("single_v_after", 32'(commit_v_o), 32'd0);

    // All cores streaming, consumed every cycle: ids rotate 0,1,2,3,0,1.
    do_reset();
    start_run();
    push_exp(0, 0); push_exp(1, 0); push_exp(2, 0); push_exp(3, 0);
    push_exp(0, 1); push_exp(1, 1);
    stream_mask = 4'b1111;
    yumi_en     = 1'b1;
    hs_limit    = 6;
    for (int c = 0; c < 40 && hs_cnt < 6; c++) apply_stimulus();
    check_output("rr_handshakes", 32'(hs_cnt), 32'd6);
    stream_mask = '0;
    yumi_en     = 1'b0;

    // Cap of 5: exactly five records consumed, then a clean pass.
    do_reset();
    instr_cap_i = 32'd5;
    start_run();
    push_exp(0, 0); push_exp(1, 0); push_exp(2, 0); push_exp(3, 0); push_exp(0, 1);
    stream_mask = 4'b1111;
    yumi_en     = 1'b1;
    repeat (20) apply_stimulus();
    #1;
    check_output("cap_handshakes", 32'(hs_cnt), 32'd5);
    check_output("cap_instr_cnt", instr_cnt_o, 32'd5);
    check_output("cap_done", 32'(done_o), 32'd1);
    check_output("cap_pass", 32'(pass_o), 32'd1);
    check_output("cap_fail", 32'(fail_o), 32'd0);
    check_output("cap_commit_v", 32'(commit_v_o), 32'd0);
    check_output("cap_ready", 32'(commit_ready_and_o), 32'd0);

    // Output held for 10 cycles without yumi: record stable, at most one more accept per core.
    do_reset();
    start_run();
    stream_mask = 4'b1111;
    apply_stimulus();
    for (int i = 0; i < N; i++) base[i] = acc_cnt[i];
    for (int c = 0; c < 10; c++) begin
      apply_stimulus();
      #1;
      check_output("stall_id", 32'(commit_id_o), 32'd0);
      check_output("stall_data", 32'(commit_data_o), 32'(rec(0, 0)));
    end
    for (int i = 0; i < N; i++)
      check_output("stall_accepts", 32'(acc_cnt[i] - base[i]), (i == 0) ? 32'd1 : 32'd0);
    push_exp(0, 0);
    yumi_en  = 1'b1;
    hs_limit = 1;
    apply_stimulus();
    check_output("stall_release", 32'(hs_cnt), 32'd1);
    yumi_en     = 1'b0;
    stream_mask = '0;

    // Mismatch on the same consume that reaches the cap: failure wins.
    do_reset();
    instr_cap_i = 32'd2;
    start_run();
    push_exp(0, 0); push_exp(1, 0);
    stream_mask = 4'b1111;
    yumi_en     = 1'b1;
    mm_at_hs    = 1;
    repeat (10) apply_stimulus();
    #1;
    check_output("mm_handshakes", 32'(hs_cnt), 32'd2);
    check_output("mm_instr_cnt", instr_cnt_o, 32'd2);
    check_output("mm_done", 32'(done_o), 32'd1);
    check_output("mm_fail", 32'(fail_o), 32'd1);
    check_output("mm_pass", 32'(pass_o), 32'd0);

`ifdef BP_COSIM_ARB_WATCHDOG_EN
    // Watchdog trips on the sixteenth consecutive unconsumed cycle.
    do_reset();
    start_run();
    stream_mask = 4'b0001;
    apply_stimulus();
    stream_mask = '0;
    repeat (TO - 1) apply_stimulus();
    #1;
    check_output("wd_not_yet", 32'(done_o), 32'd0);
    apply_stimulus();
    #1;
    check_output("wd_done", 32'(done_o), 32'd1);
    check_output("wd_fail", 32'(fail_o), 32'd1);
    check_output("wd_pass", 32'(pass_o), 32'd0);
`endif

    // Reset mid-stream clears everything immediately; nothing stale is granted afterwards.
    do_reset();
    start_run();
    stream_mask = 4'b1111;
    repeat (3) apply_stimulus();
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_output("midrst_commit_v", 32'(commit_v_o), 32'd0);
    check_output("midrst_data", 32'(commit_data_o), 32'd0);
    check_output("midrst_status", 32'({done_o, pass_o, fail_o}), 32'd0);
    check_output("midrst_ready", 32'(commit_ready_and_o), 32'd0);
    stream_mask = '0;
    commit_v_i  = '0;
    en_i        = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    en_i      = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply_stimulus();
      #1;
      check_output("no_stale_grant", 32'(commit_v_o), 32'd0);
    end
    check_output("buffers_empty", 32'(commit_ready_and_o), 32'hF);

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
